// File: rtl/cpu8_pkg.sv
// Shared encodings for the 8-bit CPU: condition codes and flag bit positions.
package cpu8_pkg;

  localparam logic [3:0] COND_NV = 4'd0;
  localparam logic [3:0] COND_AL = 4'd1;
  localparam logic [3:0] COND_EQ = 4'd2;
  localparam logic [3:0] COND_NE = 4'd3;
  localparam logic [3:0] COND_CS = 4'd4;
  localparam logic [3:0] COND_CC = 4'd5;
  localparam logic [3:0] COND_MI = 4'd6;
  localparam logic [3:0] COND_PL = 4'd7;
  localparam logic [3:0] COND_VS = 4'd8;
  localparam logic [3:0] COND_VC = 4'd9;
  localparam logic [3:0] COND_HI = 4'd10;
  localparam logic [3:0] COND_LS = 4'd11;
  localparam logic [3:0] COND_GE = 4'd12;
  localparam logic [3:0] COND_LT = 4'd13;
  localparam logic [3:0] COND_GT = 4'd14;
  localparam logic [3:0] COND_LE = 4'd15;

  // flags vector is {Z,N,C,V}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/cpu8_cond_eval.sv
// Combinational condition-code evaluator; also used by the interrupt-mask logic.
module cpu8_cond_eval
  import cpu8_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic z, n, c, v;
  assign z = flags[FLG_Z];
  assign n = flags[FLG_N];
  assign c = flags[FLG_C];
  assign v = flags[FLG_V];

  // decode the condition against the supplied flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NV: taken = 1'b0;
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu8_cond_stage.sv
// Flag/branch-resolve stage: flag register, registered branch decision with
// valid/ready handshake, and a saturating taken-branch counter.
module cpu8_cond_stage
  import cpu8_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_result,
  input  logic             in_carry,
  input  logic             in_ovf,
  input  logic             in_flag_we,
  input  logic             in_is_br,
  input  logic [3:0]       in_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] taken_cnt
);

  logic       accept;
  logic [3:0] flags_new;
  logic [3:0] flags_fwd;
  logic       eval_taken;

  // single output register: a new beat can enter whenever the slot drains this cycle
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // flags derived from this beat; Z tests the whole result vector
  always_comb begin
    flags_new        = '0;
    flags_new[FLG_Z] = (in_result == '0);
    flags_new[FLG_N] = in_result[DW-1];
    flags_new[FLG_C] = in_carry;
    flags_new[FLG_V] = in_ovf;
  end

  // forward this beat's flags so compare-and-branch resolves in one beat
  assign flags_fwd = in_flag_we ? flags_new : flags;

  cpu8_cond_eval u_eval (
    .cond  (in_cond),
    .flags (flags_fwd),
    .taken (eval_taken)
  );

  // architectural flag register, written only by accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   flags <= '0;
    else if (accept && in_flag_we) flags <= flags_new;
  end

  // decision register: load on accepted branch, otherwise drain on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_taken <= 1'b0;
    end else if (accept && in_is_br) begin
      out_valid <= 1'b1;
      out_taken <= eval_taken;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // saturating count of accepted taken branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      taken_cnt <= '0;
    else if (accept && in_is_br && eval_taken && (taken_cnt != {CNT_W{1'b1}}))
      taken_cnt <= taken_cnt + 1'b1;
  end

endmodule

// File: tb/tb_cpu8_cond_stage.sv
// Directed bench for cpu8_cond_stage (counter width 4 to reach saturation quickly).
module tb_cpu8_cond_stage;

  localparam int DW    = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [DW-1:0]    in_result;
  logic             in_carry, in_ovf, in_flag_we, in_is_br;
  logic [3:0]       in_cond;
  logic             out_valid, out_ready, out_taken;
  logic [3:0]       flags;
  logic [CNT_W-1:0] taken_cnt;

  int nvec = 0;
  int nerr = 0;
  int hs   = 0;
  int hs0;

  logic [3:0]       fl;    // expected flags {Z,N,C,V}
  logic [CNT_W-1:0] ecnt;  // expected taken count

  always #5 clk = ~clk;

  cpu8_cond_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_ovf(in_ovf),
    .in_flag_we(in_flag_we), .in_is_br(in_is_br), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .flags(flags), .taken_cnt(taken_cnt)
  );

  // count output handshakes to catch dropped or duplicated decisions
  always @(posedge clk)
    if (rst_n && out_valid && out_ready) hs = hs + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cref(input logic [3:0] cd, input logic [3:0] f);
    logic z, n, c, v;
    {z, n, c, v} = f;
    case (cd)
      4'd0:  return 1'b0;
      4'd1:  return 1'b1;
      4'd2:  return z;
      4'd3:  return ~z;
      4'd4:  return c;
      4'd5:  return ~c;
      4'd6:  return n;
      4'd7:  return ~n;
      4'd8:  return v;
      4'd9:  return ~v;
      4'd10: return c & ~z;
      4'd11: return ~c | z;
      4'd12: return ~(n ^ v);
      4'd13: return n ^ v;
      4'd14: return ~z & ~(n ^ v);
      default: return z | (n ^ v);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  // one accepted beat with out_ready=1; etk<0 takes the expected decision from cref
  task automatic beat(input logic [7:0] r, input logic c, input logic v, input logic we,
                      input logic br, input logic [3:0] cd, input int etk);
    logic [3:0] nf, fwd;
    logic       tk;
    nf  = {(r == 8'h00), r[7], c, v};
    fwd = we ? nf : fl;
    tk  = (etk < 0) ? cref(cd, fwd) : etk[0];
    in_result = r; in_carry = c; in_ovf = v; in_flag_we = we; in_is_br = br; in_cond = cd;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (we) fl = nf;
    if (br && tk) ecnt = sat_inc(ecnt);
    chk("flags", flags, fl);
    chk("out_valid", out_valid, br);
    if (br) chk($sformatf("taken c%0d f%b", cd, fwd), out_taken, tk);
    chk("taken_cnt", taken_cnt, ecnt);
  endtask

  initial begin
    logic [7:0] pr [8];
    logic [1:0] pcv[8];
    pr  = '{8'h00, 8'h01, 8'h80, 8'h01, 8'h01, 8'h80, 8'h00, 8'hC0};
    pcv = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_result = '0; in_carry = 0; in_ovf = 0; in_flag_we = 0; in_is_br = 0; in_cond = '0;
    fl = '0; ecnt = '0;
    #12;
    chk("rst flags", flags, 4'b0000);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_taken", out_taken, 1'b0);
    chk("rst cnt", taken_cnt, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after rst", in_ready, 1'b1);

    // Z over full width, and forwarding from the same beat
    beat(8'h02, 0, 0, 1, 1, 4'd2, 0);
    chk("Z not bit0", flags, 4'b0000);
    beat(8'h00, 0, 0, 1, 1, 4'd2, 1);
    chk("Z set", flags, 4'b1000);
    beat(8'h01, 0, 0, 1, 0, 4'd0, -1);
    beat(8'h00, 0, 0, 1, 1, 4'd2, 1);   // forwarded Z

    // signed conditions on registered flags
    beat(8'h80, 1, 0, 1, 0, 4'd0, -1);  // flags 0110
    chk("flags N C", flags, 4'b0110);
    beat(8'h00, 0, 0, 0, 1, 4'd13, 1);  // LT
    beat(8'h00, 0, 0, 0, 1, 4'd12, 0);  // GE
    beat(8'h80, 0, 1, 1, 1, 4'd14, 1);  // GT with N=1 V=1 Z=0
    chk("flags N V", flags, 4'b0101);

    // all 16 codes over several flag patterns
    for (int p = 0; p < 8; p++) begin
      beat(pr[p], pcv[p][1], pcv[p][0], 1, 0, 4'd0, -1);
      for (int cd = 0; cd < 16; cd++) beat(8'h00, 0, 0, 0, 1, 4'(cd), -1);
    end

    // idle input with garbage result and enables must not change state
    in_result = 'x; in_flag_we = 1; in_is_br = 1; in_cond = 4'd1; in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle flags", flags, fl);
    chk("idle out_valid", out_valid, 1'b0);
    chk("idle cnt", taken_cnt, ecnt);

    // backpressure
    out_ready = 1'b0;
    in_result = 8'h55; in_carry = 0; in_ovf = 0; in_flag_we = 1; in_is_br = 1; in_cond = 4'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    fl = 4'b0000; ecnt = sat_inc(ecnt);
    chk("bp first valid", out_valid, 1'b1);
    chk("bp first taken", out_taken, 1'b1);
    hs0 = hs;
    in_result = 8'h00; in_cond = 4'd0;   // waiting beat: NV, would set Z
    for (int i = 0; i < 3; i++) begin
      chk("bp in_ready", in_ready, 1'b0);
      chk("bp taken stable", out_taken, 1'b1);
      chk("bp valid stable", out_valid, 1'b1);
      chk("bp flags frozen", flags, 4'b0000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fl = 4'b1000;
    chk("b2b valid", out_valid, 1'b1);
    chk("b2b taken", out_taken, 1'b0);
    chk("b2b flags", flags, 4'b1000);
    @(posedge clk); #1;
    chk("b2b drained", out_valid, 1'b0);
    chk("b2b handshakes", hs - hs0, 2);
    chk("b2b cnt", taken_cnt, ecnt);

    // reset mid-operation with a pending decision
    out_ready = 1'b0;
    beat(8'h80, 1, 1, 1, 1, 4'd1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst flags", flags, 4'b0000);
    chk("midrst cnt", taken_cnt, '0);
    fl = '0; ecnt = '0;
    out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // saturating counter
    for (int i = 0; i < 20; i++) beat(8'h01, 0, 0, 0, 1, 4'd1, 1);
    chk("cnt saturated", taken_cnt, 4'hF);
    beat(8'h01, 0, 0, 0, 1, 4'd0, 0);
    chk("cnt NV unchanged", taken_cnt, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
